// File: rtl/sat_pkg.sv
// Shared Sat Engine types: default widths, per-level state FSM encoding and
// the {has_bkt, dcd_bin} entry layout with pack/unpack helpers.
package sat_pkg;

   localparam int WIDTH_BIN = 10;
   localparam int WIDTH_LVL = 16;

   typedef enum logic [1:0] {
      LVL_IDLE,
      LVL_SCAN,
      LVL_DONE
   } lvl_state_e;

   typedef struct packed {
      logic                 has_bkt;
      logic [WIDTH_BIN-1:0] dcd_bin;
   } lvl_entry_t;

   function automatic lvl_entry_t pack_entry(input logic has_bkt,
                                             input logic [WIDTH_BIN-1:0] dcd_bin);
      lvl_entry_t e;
      e.has_bkt = has_bkt;
      e.dcd_bin = dcd_bin;
      return e;
   endfunction

   function automatic logic entry_has_bkt(input lvl_entry_t e);
      return e.has_bkt;
   endfunction

endpackage

// File: rtl/lvl_state_entry.sv
// One decision level's state: the bin it was decided in and whether it has
// already been backtracked. Load beats clear beats set-bkt beats decide.
module lvl_state_entry #(
   parameter int WIDTH_BIN = sat_pkg::WIDTH_BIN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld,
   input  logic [WIDTH_BIN:0]   ld_data,
   input  logic                 clr,
   input  logic                 set_bkt,
   input  logic                 dcd,
   input  logic [WIDTH_BIN-1:0] dcd_bin_in,
   output logic                 has_bkt,
   output logic [WIDTH_BIN-1:0] dcd_bin
);

   // NOTE: the per-level store is plain flops, not a RAM, so every entry is
   // async-reset; lvl_states_o must read all-zero straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         has_bkt <= 1'b0;
         dcd_bin <= '0;
      end else if (ld) begin
         has_bkt <= ld_data[WIDTH_BIN];
         dcd_bin <= ld_data[WIDTH_BIN-1:0];
      end else if (clr) begin
         has_bkt <= 1'b0;
         dcd_bin <= '0;
      end else if (set_bkt) begin
         has_bkt <= 1'b1;
      end else if (dcd) begin
         has_bkt <= 1'b0;
         dcd_bin <= dcd_bin_in;
      end
   end

endmodule

// File: rtl/lvl_state_array.sv
// Per-level decision state store with a one-level-per-cycle backward search
// for the highest not-yet-backtracked level, backtrack apply and bulk load.
module lvl_state_array #(
   parameter int NUM_LVLS         = 8,
   parameter int WIDTH_BIN        = sat_pkg::WIDTH_BIN,
   parameter int WIDTH_LVL        = sat_pkg::WIDTH_LVL,
   parameter int WIDTH_LVL_STATES = WIDTH_BIN + 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 dcd_valid_i,
   input  logic [WIDTH_LVL-1:0]                 dcd_lvl_i,
   input  logic [WIDTH_BIN-1:0]                 cur_bin_num_i,
   input  logic                                 find_start_i,
   input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 found_o,
   output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
   output logic [WIDTH_BIN-1:0]                 bkt_bin_o,
   input  logic                                 apply_bkt_i,
   input  logic                                 wr_states,
   input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
   output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o
);

   localparam int                   EW      = WIDTH_LVL_STATES;
   localparam logic [WIDTH_LVL-1:0] MAX_IDX = WIDTH_LVL'(NUM_LVLS - 1);

   sat_pkg::lvl_state_e state_q, state_d;
   logic [WIDTH_LVL-1:0] cnt_q, cnt_d;
   logic [WIDTH_LVL-1:0] bkt_lvl_q, bkt_lvl_d;
   logic [WIDTH_BIN-1:0] bkt_bin_q, bkt_bin_d;
   logic                 found_q, found_d;

   logic                 has_bkt [NUM_LVLS];
   logic [WIDTH_BIN-1:0] dcd_bin [NUM_LVLS];

   logic                 idle;
   logic                 apply_acc;
   logic                 find_acc;
   logic                 dcd_acc;
   logic                 sel_has_bkt;
   logic [WIDTH_BIN-1:0] sel_bin;

   // Request arbitration: wr_states > apply > find > decide, IDLE only.
   assign idle      = (state_q == sat_pkg::LVL_IDLE);
   assign apply_acc = idle && !wr_states && apply_bkt_i && found_q;
   assign find_acc  = idle && !wr_states && !apply_acc && find_start_i;
   assign dcd_acc   = idle && !wr_states && !apply_acc && !find_start_i &&
                      dcd_valid_i && (dcd_lvl_i != '0) &&
                      (dcd_lvl_i < WIDTH_LVL'(NUM_LVLS));

   // Entry under examination during SCAN.
   always_comb begin
      sel_has_bkt = 1'b0;
      sel_bin     = '0;
      for (int i = 0; i < NUM_LVLS; i++) begin
         if (cnt_q == WIDTH_LVL'(i)) begin
            sel_has_bkt = has_bkt[i];
            sel_bin     = dcd_bin[i];
         end
      end
   end

   // NOTE: every variable is defaulted first so no path through the case
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bkt_lvl_d = bkt_lvl_q;
      bkt_bin_d = bkt_bin_q;
      found_d   = found_q;

      if (wr_states) begin
         if (!idle) begin
            state_d = sat_pkg::LVL_IDLE;
            found_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            sat_pkg::LVL_IDLE: begin
               if (apply_acc) begin
                  found_d = 1'b0;
               end else if (find_acc) begin
                  found_d = 1'b0;
                  if (max_lvl_i == '0) begin
                     state_d = sat_pkg::LVL_DONE;
                  end else begin
                     cnt_d   = (max_lvl_i > MAX_IDX) ? MAX_IDX : max_lvl_i;
                     state_d = sat_pkg::LVL_SCAN;
                  end
               end
            end
            sat_pkg::LVL_SCAN: begin
               if (!sel_has_bkt) begin
                  bkt_lvl_d = cnt_q;
                  bkt_bin_d = sel_bin;
                  found_d   = 1'b1;
                  state_d   = sat_pkg::LVL_DONE;
               end else if (cnt_q == WIDTH_LVL'(1)) begin
                  found_d = 1'b0;
                  state_d = sat_pkg::LVL_DONE;
               end else begin
                  cnt_d = cnt_q - WIDTH_LVL'(1);
               end
            end
            sat_pkg::LVL_DONE: begin
               state_d = sat_pkg::LVL_IDLE;
            end
            default: begin
               state_d = sat_pkg::LVL_IDLE;
            end
         endcase
      end
   end

   // NOTE: state registers take non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= sat_pkg::LVL_IDLE;
         cnt_q     <= '0;
         bkt_lvl_q <= '0;
         bkt_bin_q <= '0;
         found_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bkt_lvl_q <= bkt_lvl_d;
         bkt_bin_q <= bkt_bin_d;
         found_q   <= found_d;
      end
   end

   assign busy_o    = !idle;
   assign done_o    = (state_q == sat_pkg::LVL_DONE);
   assign found_o   = found_q;
   assign bkt_lvl_o = bkt_lvl_q;
   assign bkt_bin_o = bkt_bin_q;

   // Level i lives in slot NUM_LVLS-1-i, so level 0 occupies the MSBs.
   for (genvar i = 0; i < NUM_LVLS; i++) begin : g_lvl
      localparam int                   SLOT = NUM_LVLS - 1 - i;
      localparam logic [WIDTH_LVL-1:0] LVL  = WIDTH_LVL'(i);

      logic lvl_dcd;
      logic lvl_set_bkt;
      logic lvl_clr;

      if (i == 0) begin : g_root
         // The root level is only ever changed by a bulk load.
         assign lvl_dcd     = 1'b0;
         assign lvl_set_bkt = 1'b0;
         assign lvl_clr     = 1'b0;
      end else begin : g_dec
         assign lvl_dcd     = dcd_acc && (dcd_lvl_i == LVL);
         assign lvl_set_bkt = apply_acc && (bkt_lvl_q == LVL);
         assign lvl_clr     = apply_acc && (LVL > bkt_lvl_q);
      end

      lvl_state_entry #(
         .WIDTH_BIN (WIDTH_BIN)
      ) u_entry (
         .clk        (clk),
         .rst        (rst),
         .ld         (wr_states),
         .ld_data    (lvl_states_i[SLOT*EW +: EW]),
         .clr        (lvl_clr),
         .set_bkt    (lvl_set_bkt),
         .dcd        (lvl_dcd),
         .dcd_bin_in (cur_bin_num_i),
         .has_bkt    (has_bkt[i]),
         .dcd_bin    (dcd_bin[i])
      );

      assign lvl_states_o[SLOT*EW +: EW] = {has_bkt[i], dcd_bin[i]};
   end

endmodule

// File: tb/tb_lvl_state_array.sv
// Directed self-checking bench for lvl_state_array: decide, search, apply,
// load/abort, reset mid-search and same-cycle request priority.
module tb_lvl_state_array;
   import sat_pkg::*;

   localparam int NL = 8;
   localparam int EW = 11;
   localparam int SW = NL * EW;

   logic          clk;
   logic          rst;
   logic          dcd_valid_i;
   logic [15:0]   dcd_lvl_i;
   logic [9:0]    cur_bin_num_i;
   logic          find_start_i;
   logic [15:0]   max_lvl_i;
   logic          busy_o;
   logic          done_o;
   logic          found_o;
   logic [15:0]   bkt_lvl_o;
   logic [9:0]    bkt_bin_o;
   logic          apply_bkt_i;
   logic          wr_states;
   logic [SW-1:0] lvl_states_i;
   logic [SW-1:0] lvl_states_o;

   int checks   = 0;
   int failures = 0;

   lvl_state_array dut (
      .clk           (clk),
      .rst           (rst),
      .dcd_valid_i   (dcd_valid_i),
      .dcd_lvl_i     (dcd_lvl_i),
      .cur_bin_num_i (cur_bin_num_i),
      .find_start_i  (find_start_i),
      .max_lvl_i     (max_lvl_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .found_o       (found_o),
      .bkt_lvl_o     (bkt_lvl_o),
      .bkt_bin_o     (bkt_bin_o),
      .apply_bkt_i   (apply_bkt_i),
      .wr_states     (wr_states),
      .lvl_states_i  (lvl_states_i),
      .lvl_states_o  (lvl_states_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SW-1:0] set_slot(input logic [SW-1:0] v, input int lvl,
                                              input lvl_entry_t e);
      logic [SW-1:0] r;
      r = v;
      r[(NL-1-lvl)*EW +: EW] = e;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic decide(input logic [15:0] lvl, input logic [9:0] bin);
      dcd_valid_i   = 1'b1;
      dcd_lvl_i     = lvl;
      cur_bin_num_i = bin;
      step();
      dcd_valid_i   = 1'b0;
   endtask

   task automatic load(input logic [SW-1:0] v);
      lvl_states_i = v;
      wr_states    = 1'b1;
      step();
      wr_states    = 1'b0;
   endtask

   task automatic apply();
      apply_bkt_i = 1'b1;
      step();
      apply_bkt_i = 1'b0;
   endtask

   // Returns the cycle (relative to the start edge T) in which done_o is seen.
   task automatic run_search(input logic [15:0] max, output int n);
      max_lvl_i    = max;
      find_start_i = 1'b1;
      step();
      find_start_i = 1'b0;
      n = 1;
      while (done_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   logic [SW-1:0] exp_s;
   logic [SW-1:0] ld_v;
   int            n;
   int            done_seen;

   initial begin
      rst           = 1'b0;
      dcd_valid_i   = 1'b0;
      dcd_lvl_i     = '0;
      cur_bin_num_i = '0;
      find_start_i  = 1'b0;
      max_lvl_i     = '0;
      apply_bkt_i   = 1'b0;
      wr_states     = 1'b0;
      lvl_states_i  = '0;
      step();
      step();
      check("rst_states", lvl_states_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_found", found_o, 0);
      rst = 1'b1;
      step();

      // Decisions on levels 1..3; level 0 and out-of-range level are ignored.
      decide(16'd1, 10'd5);
      decide(16'd2, 10'd9);
      decide(16'd3, 10'd12);
      decide(16'd0, 10'd7);
      decide(16'd8, 10'd3);
      exp_s = '0;
      exp_s = set_slot(exp_s, 1, pack_entry(1'b0, 10'd5));
      exp_s = set_slot(exp_s, 2, pack_entry(1'b0, 10'd9));
      exp_s = set_slot(exp_s, 3, pack_entry(1'b0, 10'd12));
      check("decide_states", lvl_states_o, exp_s);

      // Level 3 free: one level examined, done at T+2.
      run_search(16'd3, n);
      check("s1_latency", n, 2);
      check("s1_busy_done", busy_o, 1);
      check("s1_found", found_o, 1);
      check("s1_bkt_lvl", bkt_lvl_o, 3);
      check("s1_bkt_bin", bkt_bin_o, 12);
      step();
      check("s1_done_pulse", done_o, 0);
      check("s1_idle", busy_o, 0);
      check("s1_found_hold", found_o, 1);
      apply();
      exp_s = set_slot(exp_s, 3, pack_entry(1'b1, 10'd12));
      check("s1_apply_states", lvl_states_o, exp_s);
      check("s1_apply_found", found_o, 0);

      // Levels 2,3 backtracked; root and level 5 non-zero to see clear/hold.
      ld_v = '0;
      ld_v = set_slot(ld_v, 0, pack_entry(1'b1, 10'd77));
      ld_v = set_slot(ld_v, 1, pack_entry(1'b0, 10'd5));
      ld_v = set_slot(ld_v, 2, pack_entry(1'b1, 10'd9));
      ld_v = set_slot(ld_v, 3, pack_entry(1'b1, 10'd12));
      ld_v = set_slot(ld_v, 5, pack_entry(1'b1, 10'd33));
      load(ld_v);
      check("s2_load", lvl_states_o, ld_v);
      run_search(16'd3, n);
      check("s2_latency", n, 4);
      check("s2_found", found_o, 1);
      check("s2_bkt_lvl", bkt_lvl_o, 1);
      check("s2_bkt_bin", bkt_bin_o, 5);
      step();
      apply();
      exp_s = '0;
      exp_s = set_slot(exp_s, 0, pack_entry(1'b1, 10'd77));
      exp_s = set_slot(exp_s, 1, pack_entry(1'b1, 10'd5));
      check("s2_apply_states", lvl_states_o, exp_s);

      // All levels backtracked, max clamped 20 -> 7; decide during search ignored.
      ld_v = '0;
      for (int i = 1; i < NL; i++) ld_v = set_slot(ld_v, i, pack_entry(1'b1, 10'(i * 3)));
      load(ld_v);
      dcd_valid_i   = 1'b1;
      dcd_lvl_i     = 16'd1;
      cur_bin_num_i = 10'd500;
      run_search(16'd20, n);
      dcd_valid_i   = 1'b0;
      check("s3_latency", n, 8);
      check("s3_found", found_o, 0);
      step();
      apply();
      check("s3_apply_ignored", lvl_states_o, ld_v);

      // max_lvl 0: straight to DONE.
      run_search(16'd0, n);
      check("s4_latency", n, 1);
      check("s4_found", found_o, 0);
      step();

      // Load mid-search at T+2 aborts.
      ld_v = '0;
      for (int i = 1; i < NL; i++) ld_v = set_slot(ld_v, i, pack_entry(1'b1, 10'(100 + i)));
      max_lvl_i    = 16'd7;
      find_start_i = 1'b1;
      step();
      find_start_i = 1'b0;
      step();
      check("s5_busy_mid", busy_o, 1);
      load(ld_v);
      check("s5_abort_busy", busy_o, 0);
      check("s5_abort_done", done_o, 0);
      check("s5_abort_found", found_o, 0);
      check("s5_abort_states", lvl_states_o, ld_v);
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done_o === 1'b1) done_seen++;
         step();
      end
      check("s5_no_done", done_seen, 0);

      // Set up non-zero result registers, then reset mid-search.
      ld_v = set_slot(ld_v, 4, pack_entry(1'b0, 10'd66));
      load(ld_v);
      run_search(16'd7, n);
      check("s6_bkt_lvl", bkt_lvl_o, 4);
      step();
      max_lvl_i    = 16'd3;
      find_start_i = 1'b1;
      step();
      find_start_i = 1'b0;
      rst = 1'b0;
      #1;
      check("s6_rst_states", lvl_states_o, 0);
      check("s6_rst_busy", busy_o, 0);
      check("s6_rst_done", done_o, 0);
      check("s6_rst_found", found_o, 0);
      check("s6_rst_bkt_lvl", bkt_lvl_o, 0);
      check("s6_rst_bkt_bin", bkt_bin_o, 0);
      #1;
      rst = 1'b1;
      step();

      // Same-cycle decide and apply with found: only apply lands.
      ld_v = '0;
      ld_v = set_slot(ld_v, 1, pack_entry(1'b0, 10'd5));
      ld_v = set_slot(ld_v, 2, pack_entry(1'b0, 10'd9));
      ld_v = set_slot(ld_v, 3, pack_entry(1'b0, 10'd12));
      ld_v = set_slot(ld_v, 5, pack_entry(1'b0, 10'd44));
      load(ld_v);
      run_search(16'd3, n);
      check("s7_bkt_lvl", bkt_lvl_o, 3);
      step();
      dcd_valid_i   = 1'b1;
      dcd_lvl_i     = 16'd2;
      cur_bin_num_i = 10'd99;
      apply();
      dcd_valid_i   = 1'b0;
      exp_s = '0;
      exp_s = set_slot(exp_s, 1, pack_entry(1'b0, 10'd5));
      exp_s = set_slot(exp_s, 2, pack_entry(1'b0, 10'd9));
      exp_s = set_slot(exp_s, 3, pack_entry(1'b1, 10'd12));
      check("s7_prio_states", lvl_states_o, exp_s);
      check("s7_prio_found", found_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
